// File: rtl/rsa_pkg.sv
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared widths, FSM encodings and error codes for the RSA
//                key-generation sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rsa_pkg;

  localparam int KEY_W   = 32;
  localparam int PRIME_W = 16;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_PREP   = 4'd1;
  localparam logic [3:0] ST_ESEL   = 4'd2;
  localparam logic [3:0] ST_GCD    = 4'd3;
  localparam logic [3:0] ST_ENEXT  = 4'd4;
  localparam logic [3:0] ST_KICK   = 4'd5;
  localparam logic [3:0] ST_VERIFY = 4'd6;
  localparam logic [3:0] ST_DONE   = 4'd7;
  localparam logic [3:0] ST_ERR    = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE   = ST_IDLE,
    S_PREP   = ST_PREP,
    S_ESEL   = ST_ESEL,
    S_GCD    = ST_GCD,
    S_ENEXT  = ST_ENEXT,
    S_KICK   = ST_KICK,
    S_VERIFY = ST_VERIFY,
    S_DONE   = ST_DONE,
    S_ERR    = ST_ERR
  } keygen_state_t;

  typedef logic [2:0] keygen_err_t;

  localparam keygen_err_t ERR_NONE    = 3'd0;
  localparam keygen_err_t ERR_BADP    = 3'd1;
  localparam keygen_err_t ERR_NOE     = 3'd2;
  localparam keygen_err_t ERR_TIMEOUT = 3'd3;
  localparam keygen_err_t ERR_VERIFY  = 3'd4;

  function automatic logic is_busy(input keygen_state_t s);
    return !((s == S_IDLE) || (s == S_DONE) || (s == S_ERR));
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_mod.sv
// ============================================================================
//  Module      : serial_mod
//  Description : Restoring shift-subtract remainder, 32- or 64-bit dividend
//                by 32-bit divisor; one load cycle then one bit per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_mod
  import rsa_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               wide,
  input  logic [2*KEY_W-1:0] dividend,
  input  logic [KEY_W-1:0]   divisor,
  output logic [KEY_W-1:0]   rem,
  output logic               ready
);

  logic [2*KEY_W-1:0] dvd_q, dvd_d;
  logic [KEY_W-1:0]   div_q, div_d;
  logic [KEY_W-1:0]   rem_q, rem_d;
  logic [6:0]         cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic [KEY_W:0]     trial;
  logic [KEY_W-1:0]   diff;

  always_comb begin
    trial   = {rem_q, dvd_q[2*KEY_W-1]};
    // trial < 2*div, so the true difference always fits in KEY_W bits
    diff    = trial[KEY_W-1:0] - div_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (load) begin
      dvd_d   = wide ? dividend : {dividend[KEY_W-1:0], {KEY_W{1'b0}}};
      div_d   = divisor;
      rem_d   = '0;
      cnt_d   = wide ? 7'd64 : 7'd32;
      ready_d = 1'b0;
    end else if (cnt_q != 7'd0) begin
      dvd_d   = {dvd_q[2*KEY_W-2:0], 1'b0};
      rem_d   = (trial >= {1'b0, div_q}) ? diff : trial[KEY_W-1:0];
      cnt_d   = cnt_q - 7'd1;
      ready_d = (cnt_q == 7'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvd_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign rem   = rem_q;
  assign ready = ready_q;

endmodule

`default_nettype wire

// File: rtl/rsa_keygen_ctrl.sv
// ============================================================================
//  Module      : rsa_keygen_ctrl
//  Description : RSA key sequencer: n/phi, first odd e coprime to phi, then
//                drives generate_d and presents (n, e, d).
//                Optional (e*d) mod phi self-check: RSA_KEYGEN_VERIFY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsa_keygen_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32'd1048576
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [PRIME_W-1:0] p1,
  input  logic [PRIME_W-1:0] p2,
  input  logic [KEY_W-1:0]   e_min,
  output logic               gd_compute,
  output logic [KEY_W-1:0]   gd_e,
  output logic [KEY_W-1:0]   gd_phi,
  input  logic [KEY_W-1:0]   gd_d,
  input  logic               gd_done,
  output logic [KEY_W-1:0]   n,
  output logic [KEY_W-1:0]   phi,
  output logic [KEY_W-1:0]   e,
  output logic [KEY_W-1:0]   d,
  output logic               key_valid,
  output logic               busy,
  output logic [2:0]         err_code
);

  keygen_state_t      state_q, state_d;
  logic [PRIME_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [KEY_W-1:0]   emin_q, emin_d;
  logic [KEY_W-1:0]   n_q, n_d, phi_q, phi_d, e_q, e_d, d_q, d_d;
  logic [KEY_W-1:0]   a_q, a_d, b_q, b_d;
  logic               wait_q, wait_d;
  logic               armed_q, armed_d;
  logic [31:0]        timer_q, timer_d;
  logic               gdc_q, gdc_d;
  logic [KEY_W-1:0]   gde_q, gde_d, gdphi_q, gdphi_d;
  logic               kv_q, kv_d;
  keygen_err_t        err_q, err_d;

  logic               mod_load, mod_wide, mod_ready;
  logic [2*KEY_W-1:0] mod_dividend;
  logic [KEY_W-1:0]   mod_divisor, mod_rem;
  logic [KEY_W-1:0]   e_cand;
  logic [KEY_W:0]     e_step;
  logic [KEY_W-1:0]   p1_ext, p2_ext;

`ifdef RSA_KEYGEN_VERIFY_EN
  logic [2*KEY_W-1:0] ed_prod;
  assign ed_prod = {{KEY_W{1'b0}}, e_q} * {{KEY_W{1'b0}}, d_q};
`endif

  assign p1_ext = {{(KEY_W-PRIME_W){1'b0}}, p1_q};
  assign p2_ext = {{(KEY_W-PRIME_W){1'b0}}, p2_q};

  serial_mod u_mod (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (mod_load),
    .wide     (mod_wide),
    .dividend (mod_dividend),
    .divisor  (mod_divisor),
    .rem      (mod_rem),
    .ready    (mod_ready)
  );

  always_comb begin
    state_d      = state_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    emin_d       = emin_q;
    n_d          = n_q;
    phi_d        = phi_q;
    e_d          = e_q;
    d_d          = d_q;
    a_d          = a_q;
    b_d          = b_q;
    wait_d       = wait_q;
    armed_d      = armed_q;
    timer_d      = timer_q;
    gdc_d        = gdc_q;
    gde_d        = gde_q;
    gdphi_d      = gdphi_q;
    kv_d         = kv_q;
    err_d        = err_q;
    mod_load     = 1'b0;
    mod_wide     = 1'b0;
    mod_dividend = {{KEY_W{1'b0}}, a_q};
    mod_divisor  = b_q;
    e_cand       = (emin_q < 32'd3) ? 32'd3 : emin_q;
    e_step       = {1'b0, e_q} + 33'd2;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          p1_d    = p1;
          p2_d    = p2;
          emin_d  = e_min | 32'd1;
          kv_d    = 1'b0;
          err_d   = ERR_NONE;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        if ((p1_q < 16'd3) || (p2_q < 16'd3)) begin
          err_d   = ERR_BADP;
          state_d = S_ERR;
        end else begin
          n_d     = p1_ext * p2_ext;
          phi_d   = (p1_ext - 32'd1) * (p2_ext - 32'd1);
          state_d = S_ESEL;
        end
      end

      S_ESEL: begin
        if (e_cand >= phi_q) begin
          err_d   = ERR_NOE;
          state_d = S_ERR;
        end else begin
          e_d     = e_cand;
          a_d     = phi_q;
          b_d     = e_cand;
          wait_d  = 1'b0;
          state_d = S_GCD;
        end
      end

      // Euclid: a <- b, b <- a mod b until b = 0; gcd is then in a
      S_GCD: begin
        if (!wait_q) begin
          if (b_q == '0) begin
            if (a_q == 32'd1) begin
              gdc_d   = 1'b1;
              gde_d   = e_q;
              gdphi_d = phi_q;
              timer_d = '0;
              armed_d = 1'b0;
              state_d = S_KICK;
            end else begin
              state_d = S_ENEXT;
            end
          end else begin
            mod_load = 1'b1;
            wait_d   = 1'b1;
          end
        end else if (mod_ready) begin
          a_d    = b_q;
          b_d    = mod_rem;
          wait_d = 1'b0;
        end
      end

      S_ENEXT: begin
        if (e_step[KEY_W] || (e_step[KEY_W-1:0] >= phi_q)) begin
          err_d   = ERR_NOE;
          state_d = S_ERR;
        end else begin
          e_d     = e_step[KEY_W-1:0];
          a_d     = phi_q;
          b_d     = e_step[KEY_W-1:0];
          state_d = S_GCD;
        end
      end

      // A done already high on entry is stale; only accept one seen after a low
      S_KICK: begin
        armed_d = armed_q | ~gd_done;
        if (gd_done && armed_q) begin
          d_d   = gd_d;
          gdc_d = 1'b0;
`ifdef RSA_KEYGEN_VERIFY_EN
          wait_d  = 1'b0;
          state_d = S_VERIFY;
`else
          kv_d    = 1'b1;
          state_d = S_DONE;
`endif
        end else if (timer_q >= (TIMEOUT - 32'd1)) begin
          gdc_d   = 1'b0;
          err_d   = ERR_TIMEOUT;
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

`ifdef RSA_KEYGEN_VERIFY_EN
      S_VERIFY: begin
        mod_wide     = 1'b1;
        mod_dividend = ed_prod;
        mod_divisor  = phi_q;
        if (!wait_q) begin
          mod_load = 1'b1;
          wait_d   = 1'b1;
        end else if (mod_ready) begin
          if (mod_rem == 32'd1) begin
            kv_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = ERR_VERIFY;
            state_d = S_ERR;
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      emin_q  <= '0;
      n_q     <= '0;
      phi_q   <= '0;
      e_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wait_q  <= 1'b0;
      armed_q <= 1'b0;
      timer_q <= '0;
      gdc_q   <= 1'b0;
      gde_q   <= '0;
      gdphi_q <= '0;
      kv_q    <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      emin_q  <= emin_d;
      n_q     <= n_d;
      phi_q   <= phi_d;
      e_q     <= e_d;
      d_q     <= d_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wait_q  <= wait_d;
      armed_q <= armed_d;
      timer_q <= timer_d;
      gdc_q   <= gdc_d;
      gde_q   <= gde_d;
      gdphi_q <= gdphi_d;
      kv_q    <= kv_d;
      err_q   <= err_d;
    end
  end

  assign gd_compute = gdc_q;
  assign gd_e       = gde_q;
  assign gd_phi     = gdphi_q;
  assign n          = n_q;
  assign phi        = phi_q;
  assign e          = e_q;
  assign d          = d_q;
  assign key_valid  = kv_q;
  assign busy       = is_busy(state_q);
  assign err_code   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rsa_keygen_ctrl.sv
// ============================================================================
//  Module      : tb_rsa_keygen_ctrl
//  Description : Directed bench for rsa_keygen_ctrl with a generate_d stub
//                and an arithmetic key model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rsa_keygen_ctrl;

  localparam int unsigned TO = 100;
`ifdef RSA_KEYGEN_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] p1;
    logic [15:0] p2;
    logic [31:0] em;
    logic [31:0] dd;
    int          mode;   // 0 prompt done, 1 never done, 2 stale done first
    logic [2:0]  lerr;
    logic [31:0] ln;
    logic [31:0] lphi;
    logic [31:0] le;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] p1 = '0, p2 = '0;
  logic [31:0] e_min = '0;
  logic        gd_compute;
  logic [31:0] gd_e, gd_phi;
  logic [31:0] gd_d = '0;
  logic        gd_done = 1'b0;
  logic [31:0] n, phi, e, d;
  logic        key_valid, busy;
  logic [2:0]  err_code;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          stub_mode = 0;
  int          stub_cnt = 0;
  logic [31:0] stub_d = '0;
  logic [2:0]  exp_err = '0;
  logic [31:0] exp_n = '0, exp_phi = '0, exp_e = '0, exp_d = '0;
  vec_t        vecs[7];

  rsa_keygen_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .p1         (p1),
    .p2         (p2),
    .e_min      (e_min),
    .gd_compute (gd_compute),
    .gd_e       (gd_e),
    .gd_phi     (gd_phi),
    .gd_d       (gd_d),
    .gd_done    (gd_done),
    .n          (n),
    .phi        (phi),
    .e          (e),
    .d          (d),
    .key_valid  (key_valid),
    .busy       (busy),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  // generate_d stand-in
  always @(posedge clk) begin
    if (!gd_compute) begin
      stub_cnt <= 0;
      gd_done  <= (stub_mode == 2);
      gd_d     <= 32'hDEAD_BEEF;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if ((stub_mode == 0 && stub_cnt == 0) || (stub_mode == 2 && stub_cnt == 4)) begin
        gd_done <= 1'b1;
        gd_d    <= stub_d;
      end else begin
        gd_done <= 1'b0;
        gd_d    <= 32'h0BAD_0BAD;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic longint unsigned gcd(input longint unsigned x0, input longint unsigned y0);
    longint unsigned x, y, t;
    x = x0;
    y = y0;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic void model_key(input vec_t v, output logic [2:0] err,
                                    output logic [31:0] mn, output logic [31:0] mphi,
                                    output logic [31:0] me);
    longint unsigned a, b, cand, ph;
    err = 3'd0; mn = '0; mphi = '0; me = '0;
    a = longint'(v.p1);
    b = longint'(v.p2);
    if (a < 3 || b < 3) begin err = 3'd1; return; end
    ph   = (a - 1) * (b - 1);
    mn   = 32'(a * b);
    mphi = 32'(ph);
    cand = longint'(v.em) | 1;
    if (cand < 3) cand = 3;
    while (cand < ph && gcd(ph, cand) != 1) cand += 2;
    if (cand >= ph) begin err = 3'd2; return; end
    me = 32'(cand);
    if (v.mode == 1) begin err = 3'd3; return; end
    if (VERIFY_ON && ((cand * longint'(v.dd)) % ph) != 1) err = 3'd4;
  endfunction

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_ctl", {gd_compute, key_valid, busy, err_code}, 64'd0);
      check("reset_data", n | phi | e | d | gd_e | gd_phi, 64'd0);
    end else begin
      if (key_valid) begin
        check("kv_allowed", key_valid, exp_err == 3'd0);
        check("kv_err", err_code, 64'd0);
        check("kv_busy", busy, 64'd0);
        check("kv_n", n, exp_n);
        check("kv_phi", phi, exp_phi);
        check("kv_e", e, exp_e);
        check("kv_d", d, exp_d);
      end
      if (err_code != 3'd0) begin
        check("err_code", err_code, exp_err);
        check("err_kv", key_valid, 64'd0);
      end
      if (gd_compute) begin
        check("gd_e", gd_e, exp_e);
        check("gd_phi", gd_phi, exp_phi);
      end
    end
  end

  task automatic launch(input vec_t v);
    @(posedge clk); #1;
    p1 = v.p1; p2 = v.p2; e_min = v.em;
    stub_mode = v.mode; stub_d = v.dd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_key(v, exp_err, exp_n, exp_phi, exp_e);
    exp_d = v.dd;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int cyc, comp_cyc;
    bit fin, saw;
    launch(v);
    cyc = 0; comp_cyc = 0; fin = 0; saw = 0;
    while (!fin && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (gd_compute) begin saw = 1; comp_cyc++; end
      if (key_valid || err_code != 3'd0) fin = 1;
    end
    check({tag, "_completed"}, fin, 64'd1);
    check({tag, "_err"}, err_code, v.lerr);
    check({tag, "_kv"}, key_valid, v.lerr == 3'd0);
    if (v.lerr == 3'd0) begin
      check({tag, "_n"}, n, v.ln);
      check({tag, "_phi"}, phi, v.lphi);
      check({tag, "_e"}, e, v.le);
      check({tag, "_d"}, d, v.dd);
    end else if (v.lerr == 3'd1) begin
      check({tag, "_cycles"}, cyc, 64'd2);
      check({tag, "_no_compute"}, saw, 64'd0);
    end else if (v.lerr == 3'd3) begin
      check({tag, "_kick_cycles"}, comp_cyc, TO);
      check({tag, "_compute_low"}, gd_compute, 64'd0);
    end
    stub_mode = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_abort(input string tag, input vec_t v, input bit in_kick);
    int cyc;
    launch(v);
    if (in_kick) begin
      cyc = 0;
      while (!gd_compute && cyc < 3000) begin
        @(posedge clk); #1;
        cyc++;
      end
      repeat (3) @(posedge clk);
      #2;
      check({tag, "_compute_before"}, gd_compute, 64'd1);
    end else begin
      repeat (15) @(posedge clk);
      #2;
    end
    check({tag, "_busy_before"}, busy, 64'd1);
    reset_n = 1'b0;
    #1;
    check({tag, "_ctl_async"}, {gd_compute, key_valid, busy, err_code}, 64'd0);
    check({tag, "_data_async"}, n | phi | e | d | gd_e | gd_phi, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stub_mode = 0;
  endtask

  initial begin
    vecs[0] = '{16'd7,   16'd13, 32'd7,   32'd31, 0, 3'd0, 32'd91,   32'd72,   32'd7};
    vecs[1] = '{16'd7,   16'd13, 32'd3,   32'd29, 0, 3'd0, 32'd91,   32'd72,   32'd5};
    if (VERIFY_ON)
      vecs[2] = '{16'd103, 16'd79, 32'd172, 32'd4000, 0, 3'd4, 32'd8137, 32'd7956, 32'd173};
    else
      vecs[2] = '{16'd103, 16'd79, 32'd172, 32'd4001, 0, 3'd0, 32'd8137, 32'd7956, 32'd173};
    vecs[3] = '{16'd2,   16'd13, 32'd7,   32'd31, 0, 3'd1, 32'd0,    32'd0,    32'd0};
    vecs[4] = '{16'd7,   16'd13, 32'd80,  32'd31, 0, 3'd2, 32'd0,    32'd0,    32'd0};
    vecs[5] = '{16'd7,   16'd13, 32'd7,   32'd31, 2, 3'd0, 32'd91,   32'd72,   32'd7};
    vecs[6] = '{16'd7,   16'd13, 32'd7,   32'd31, 1, 3'd3, 32'd0,    32'd0,    32'd0};

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    run_vec("basic", vecs[0]);
    run_vec("enext", vecs[1]);
    run_vec("oddforce", vecs[2]);
    run_vec("badp", vecs[3]);
    run_vec("noe", vecs[4]);
    run_vec("stale_done", vecs[5]);
    run_vec("timeout", vecs[6]);
    reset_abort("rst_gcd", vecs[2], 1'b0);
    reset_abort("rst_kick", vecs[6], 1'b1);
    run_vec("after_rst", vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

`default_nettype wire
